// File: rtl/vga_ball_pixel_gen_pkg.sv
// Shared VGA constants, colour defaults and types for the bouncing-ball pixel generator.
// Used by vga_ball_pixel_gen; the optional border is enabled by defining VGA_BORDER_EN.
package vga_ball_pixel_gen_pkg;
   localparam int H_ACTIVE = 640;
   localparam int V_ACTIVE = 480;
   localparam int COLOR_W  = 12;
   localparam int POS_W    = 10;

   localparam logic [COLOR_W-1:0] BALL_COLOR_DEF   = 12'hF00;
   localparam logic [COLOR_W-1:0] BG_COLOR_DEF     = 12'h00F;
   localparam logic [COLOR_W-1:0] BORDER_COLOR_DEF = 12'hFFF;
   localparam logic [COLOR_W-1:0] BLANK_COLOR      = 12'h000;

   typedef logic [COLOR_W-1:0] rgb_t;
   typedef logic [POS_W-1:0]   pos_t;

   // Sums are 11 bits so start+size never wraps near the right/bottom edge.
   function automatic logic in_span(input pos_t c, input pos_t start, input int size);
      logic [POS_W:0] c_w;
      logic [POS_W:0] lo_w;
      logic [POS_W:0] hi_w;
      c_w  = {1'b0, c};
      lo_w = {1'b0, start};
      hi_w = lo_w + (POS_W+1)'(size);
      return (c_w >= lo_w) && (c_w < hi_w);
   endfunction
endpackage

// File: rtl/vga_ball_pixel_gen_if.sv
// Raster timing bundle from vga_sync to the pixel generator.
// master = timing source (vga_sync), slave = pixel generator.
interface vga_ball_pixel_gen_if;
   import vga_ball_pixel_gen_pkg::*;

   logic vd_on;
   logic h_sync;
   logic v_sync;
   pos_t h_count;
   pos_t v_count;

   modport master (output vd_on, h_sync, v_sync, h_count, v_count);
   modport slave  (input  vd_on, h_sync, v_sync, h_count, v_count);
endinterface

// File: rtl/vga_ball_pixel_gen_axis_bounce.sv
// One axis of ball motion: position and direction registers with clamp-and-flip at the limits.
// dir=1 moves toward larger coordinates.
module axis_bounce
   import vga_ball_pixel_gen_pkg::*;
#(
   parameter int SPEED = 2,
   parameter int POS0  = 320
) (
   input  logic clk,
   input  logic rst,
   input  logic step_en,
   input  pos_t limit_lo,
   input  pos_t limit_hi,
   output pos_t pos,
   output logic dir
);
   pos_t pos_q, pos_d;
   logic dir_q, dir_d;

   logic [POS_W:0] fwd_sum;
   logic [POS_W:0] lo_thresh;

   always_comb begin
      fwd_sum   = {1'b0, pos_q} + (POS_W+1)'(SPEED);
      lo_thresh = {1'b0, limit_lo} + (POS_W+1)'(SPEED);
      pos_d     = pos_q;
      dir_d     = dir_q;
      if (step_en) begin
         if (dir_q) begin
            if (fwd_sum > {1'b0, limit_hi}) begin
               pos_d = limit_hi;
               dir_d = 1'b0;
            end else begin
               pos_d = fwd_sum[POS_W-1:0];
            end
         end else begin
            // Stepping back would cross limit_lo: park on it and turn around.
            if ({1'b0, pos_q} < lo_thresh) begin
               pos_d = limit_lo;
               dir_d = 1'b1;
            end else begin
               pos_d = pos_q - POS_W'(SPEED);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pos_q <= POS_W'(POS0);
         dir_q <= 1'b1;
      end else begin
         pos_q <= pos_d;
         dir_q <= dir_d;
      end
   end

   assign pos = pos_q;
   assign dir = dir_q;
endmodule

// File: rtl/vga_ball_pixel_gen.sv
// Bouncing-ball pixel generator: registered colour plus 1-cycle retimed syncs, ball moves once per frame.
// Optional 1-pixel border around the visible area when VGA_BORDER_EN is defined.
module vga_ball_pixel_gen
   import vga_ball_pixel_gen_pkg::*;
#(
   parameter int   BALL_SIZE    = 16,
   parameter int   SPEED        = 2,
   parameter int   BALL_X0      = 320,
   parameter int   BALL_Y0      = 240,
   parameter rgb_t BALL_COLOR   = BALL_COLOR_DEF,
   parameter rgb_t BG_COLOR     = BG_COLOR_DEF,
   parameter rgb_t BORDER_COLOR = BORDER_COLOR_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   vga_ball_pixel_gen_if.slave  vga,
   input  logic                 pause,
   output rgb_t                 rgb_out,
   output logic                 h_sync_out,
   output logic                 v_sync_out,
   output logic                 frame_tick
);
`ifdef VGA_BORDER_EN
   localparam pos_t X_LO = POS_W'(1);
   localparam pos_t X_HI = POS_W'(H_ACTIVE - 1 - BALL_SIZE);
   localparam pos_t Y_LO = POS_W'(1);
   localparam pos_t Y_HI = POS_W'(V_ACTIVE - 1 - BALL_SIZE);
`else
   localparam pos_t X_LO = '0;
   localparam pos_t X_HI = POS_W'(H_ACTIVE - BALL_SIZE);
   localparam pos_t Y_LO = '0;
   localparam pos_t Y_HI = POS_W'(V_ACTIVE - BALL_SIZE);
`endif

   rgb_t rgb_q, rgb_d;
   logic h_sync_q, v_sync_q;
   logic frame_tick_q;

   pos_t ball_x, ball_y;
   logic dir_x, dir_y;
   logic step_en;
   logic in_ball;
   logic is_border;

   // Position only changes on the tick cycle, which falls in vertical blank.
   assign step_en = frame_tick_q & ~pause;

   axis_bounce #(.SPEED(SPEED), .POS0(BALL_X0)) u_axis_x (
      .clk      (clk),
      .rst      (rst),
      .step_en  (step_en),
      .limit_lo (X_LO),
      .limit_hi (X_HI),
      .pos      (ball_x),
      .dir      (dir_x)
   );

   axis_bounce #(.SPEED(SPEED), .POS0(BALL_Y0)) u_axis_y (
      .clk      (clk),
      .rst      (rst),
      .step_en  (step_en),
      .limit_lo (Y_LO),
      .limit_hi (Y_HI),
      .pos      (ball_y),
      .dir      (dir_y)
   );

   assign in_ball = in_span(vga.h_count, ball_x, BALL_SIZE) &&
                    in_span(vga.v_count, ball_y, BALL_SIZE);

`ifdef VGA_BORDER_EN
   assign is_border = (vga.h_count == '0) || (vga.h_count == POS_W'(H_ACTIVE - 1)) ||
                      (vga.v_count == '0) || (vga.v_count == POS_W'(V_ACTIVE - 1));
`else
   assign is_border = 1'b0;
`endif

   always_comb begin
      rgb_d = BG_COLOR;
      if (!vga.vd_on) begin
         rgb_d = BLANK_COLOR;
      end else if (in_ball) begin
         rgb_d = BALL_COLOR;
      end else if (is_border) begin
         rgb_d = BORDER_COLOR;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rgb_q        <= BLANK_COLOR;
         h_sync_q     <= 1'b1;
         v_sync_q     <= 1'b1;
         frame_tick_q <= 1'b0;
      end else begin
         rgb_q        <= rgb_d;
         h_sync_q     <= vga.h_sync;
         v_sync_q     <= vga.v_sync;
         frame_tick_q <= (vga.v_count == POS_W'(V_ACTIVE)) && (vga.h_count == '0);
      end
   end

   assign rgb_out    = rgb_q;
   assign h_sync_out = h_sync_q;
   assign v_sync_out = v_sync_q;
   assign frame_tick = frame_tick_q;
endmodule

// File: tb/tb_vga_ball_pixel_gen.sv
// Directed bench for vga_ball_pixel_gen: pixel vector table plus frame-tick, wall, pause and reset sequences.
// Expectations follow VGA_BORDER_EN when it is defined for the build.
module tb_vga_ball_pixel_gen;
   import vga_ball_pixel_gen_pkg::*;

   logic clk;
   logic rst;
   logic pause;
   rgb_t rgb_out;
   logic h_sync_out;
   logic v_sync_out;
   logic frame_tick;

   vga_ball_pixel_gen_if vif ();

   vga_ball_pixel_gen dut (
      .clk        (clk),
      .rst        (rst),
      .vga        (vif.slave),
      .pause      (pause),
      .rgb_out    (rgb_out),
      .h_sync_out (h_sync_out),
      .v_sync_out (v_sync_out),
      .frame_tick (frame_tick)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   logic [13:0] exp_q[$];

   // model of ball state, kept from the description of the motion rules
   int m_x = 320, m_y = 240;
   bit m_dx = 1'b1, m_dy = 1'b1;

`ifdef VGA_BORDER_EN
   localparam int LO_X = 1, HI_X = 623, LO_Y = 1, HI_Y = 463;
   localparam rgb_t EDGE_RGB = 12'hFFF;
`else
   localparam int LO_X = 0, HI_X = 624, LO_Y = 0, HI_Y = 464;
   localparam rgb_t EDGE_RGB = 12'h00F;
`endif

   typedef struct {
      logic       vd_on;
      int         h;
      int         v;
      logic       hs;
      logic       vs;
      rgb_t       exp_rgb;
   } vec_t;

   typedef struct {
      int   tick;
      int   x;
      logic dx;
   } ckpt_t;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp)
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      else
         n_pass++;
   endtask

   function automatic void model_axis(inout int p, inout bit d, input int lo, input int hi);
      if (d) begin
         if (p + 2 > hi) begin
            p = hi;
            d = 1'b0;
         end else begin
            p = p + 2;
         end
      end else begin
         if (p - 2 < lo) begin
            p = lo;
            d = 1'b1;
         end else begin
            p = p - 2;
         end
      end
   endfunction

   task automatic drive(input logic vd, input int h, input int v, input logic hs, input logic vs);
      vif.vd_on   = vd;
      vif.h_count = POS_W'(h);
      vif.v_count = POS_W'(v);
      vif.h_sync  = hs;
      vif.v_sync  = vs;
   endtask

   task automatic do_tick(input logic p);
      pause = p;
      drive(1'b0, 0, 480, 1'b1, 1'b0);
      step();
      check("frame_tick_hi", 32'(frame_tick), 32'd1);
      drive(1'b0, 1, 480, 1'b1, 1'b0);
      step();
      check("frame_tick_lo", 32'(frame_tick), 32'd0);
      if (!p) begin
         model_axis(m_x, m_dx, LO_X, HI_X);
         model_axis(m_y, m_dy, LO_Y, HI_Y);
      end
   endtask

   task automatic check_ball(input string name, input int x, input int y, input logic dx, input logic dy);
      check({name, "_x"},  32'(dut.ball_x), 32'(x));
      check({name, "_y"},  32'(dut.ball_y), 32'(y));
      check({name, "_dx"}, 32'(dut.dir_x),  32'(dx));
      check({name, "_dy"}, 32'(dut.dir_y),  32'(dy));
   endtask

   vec_t  vecs[12];
   ckpt_t ckpts[8];

   initial begin
      vecs[0]  = '{1'b1, 325, 245, 1'b1, 1'b1, 12'hF00};
      vecs[1]  = '{1'b1, 100, 100, 1'b0, 1'b1, 12'h00F};
      vecs[2]  = '{1'b0, 325, 245, 1'b1, 1'b0, 12'h000};
      vecs[3]  = '{1'b1, 320, 240, 1'b1, 1'b1, 12'hF00};
      vecs[4]  = '{1'b1, 335, 255, 1'b0, 1'b0, 12'hF00};
      vecs[5]  = '{1'b1, 336, 250, 1'b1, 1'b1, 12'h00F};
      vecs[6]  = '{1'b1, 330, 256, 1'b1, 1'b1, 12'h00F};
      vecs[7]  = '{1'b1, 319, 245, 1'b1, 1'b1, 12'h00F};
      vecs[8]  = '{1'b1, 320, 239, 1'b1, 1'b1, 12'h00F};
      vecs[9]  = '{1'b1, 0,   100, 1'b1, 1'b1, EDGE_RGB};
      vecs[10] = '{1'b1, 639, 479, 1'b1, 1'b1, EDGE_RGB};
      vecs[11] = '{1'b0, 0,   0,   1'b1, 1'b1, 12'h000};

`ifdef VGA_BORDER_EN
      ckpts = '{'{151, 622, 1'b1}, '{152, 623, 1'b0}, '{153, 621, 1'b0}, '{462, 3, 1'b0},
                '{463, 1, 1'b0},   '{464, 1, 1'b1},   '{465, 3, 1'b1},   '{467, 7, 1'b1}};
`else
      ckpts = '{'{151, 622, 1'b1}, '{152, 624, 1'b1}, '{153, 624, 1'b0}, '{154, 622, 1'b0},
                '{464, 2, 1'b0},   '{465, 0, 1'b0},   '{466, 0, 1'b1},   '{467, 2, 1'b1}};
`endif

      // reset, with inputs that would otherwise light the ball and drop the syncs
      rst   = 1'b1;
      pause = 1'b0;
      drive(1'b1, 325, 245, 1'b0, 1'b0);
      repeat (5) step();
      check("rst_rgb", 32'(rgb_out), 32'h000);
      check("rst_hs", 32'(h_sync_out), 32'd1);
      check("rst_vs", 32'(v_sync_out), 32'd1);
      check("rst_tick", 32'(frame_tick), 32'd0);
      check_ball("rst_ball", 320, 240, 1'b1, 1'b1);
      rst = 1'b0;

      // pixel vector table through the scoreboard queue
      for (int i = 0; i < 12; i++) begin
         logic [13:0] e;
         drive(vecs[i].vd_on, vecs[i].h, vecs[i].v, vecs[i].hs, vecs[i].vs);
         exp_q.push_back({vecs[i].exp_rgb, vecs[i].hs, vecs[i].vs});
         step();
         e = exp_q.pop_front();
         check($sformatf("vec%0d_rgb", i), 32'(rgb_out), 32'(e[13:2]));
         check($sformatf("vec%0d_hs", i), 32'(h_sync_out), 32'(e[1]));
         check($sformatf("vec%0d_vs", i), 32'(v_sync_out), 32'(e[0]));
      end

      // frame ticks: first move, right wall, left wall
      for (int t = 1; t <= 467; t++) begin
         do_tick(1'b0);
         if (t == 1) check_ball("tick1", 322, 242, 1'b1, 1'b1);
         for (int c = 0; c < 8; c++) begin
            if (ckpts[c].tick == t) begin
               check($sformatf("wall_t%0d_x", t), 32'(dut.ball_x), 32'(ckpts[c].x));
               check($sformatf("wall_t%0d_dx", t), 32'(dut.dir_x), 32'(ckpts[c].dx));
               check($sformatf("wall_t%0d_y", t), 32'(dut.ball_y), 32'(m_y));
               check($sformatf("wall_t%0d_dy", t), 32'(dut.dir_y), 32'(m_dy));
            end
         end
      end

      // pause across three ticks
      for (int k = 0; k < 3; k++) do_tick(1'b1);
      check_ball("pause", m_x, m_y, m_dx, m_dy);
      drive(1'b1, m_x + 1, m_y + 1, 1'b1, 1'b1);
      step();
      check("pause_ball_rgb", 32'(rgb_out), 32'hF00);
      drive(1'b1, m_x + 16, m_y + 1, 1'b1, 1'b1);
      step();
      check("pause_bg_rgb", 32'(rgb_out), 32'h00F);
      pause = 1'b0;

      // reset in the middle of a ball pixel
      drive(1'b1, m_x + 1, m_y + 1, 1'b0, 1'b0);
      rst = 1'b1;
      step();
      check("midrst_rgb", 32'(rgb_out), 32'h000);
      check("midrst_hs", 32'(h_sync_out), 32'd1);
      check_ball("midrst", 320, 240, 1'b1, 1'b1);
      rst = 1'b0;
      drive(1'b1, 325, 245, 1'b1, 1'b1);
      step();
      check("postrst_rgb", 32'(rgb_out), 32'hF00);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
